// File: rtl/l2_bus_bridge_pkg.sv
// Shared bus/coherence types used by the bus controller and the L2 bridge.
// Holds the L2 port handshake state and the bus word type.
package l2_bus_bridge_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        L2_FREE   = 2'd0,
        L2_BUSY   = 2'd1,
        L2_ACCESS = 2'd2,
        L2_ERROR  = 2'd3
    } l2_state_t;

    localparam logic [3:0] BYTE_EN_ALL = 4'hF;

endpackage

// File: rtl/l2_bridge_timer.sv
// Saturating timeout counter for the L2 bridge.
// expired_o is high once the count has reached CYCLES-1.
module l2_bridge_timer #(
    parameter int unsigned CYCLES = 1024
) (
    input  logic CLK,
    input  logic nRST,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [W-1:0] LAST = W'(CYCLES - 1);

    logic [W-1:0] count_q, count_d;

    assign expired_o = (count_q == LAST);

    always_comb begin
        count_d = count_q;
        if (clear_i)
            count_d = '0;
        else if (enable_i && !expired_o)
            count_d = count_q + W'(1);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            count_q <= '0;
        else
            count_q <= count_d;
    end

endmodule

// File: rtl/l2_bus_bridge.sv
// Word-level bridge from the bus controller L2 port to the memory bus.
// One transaction at a time; aborts drain cleanly, stalls time out.
module l2_bus_bridge
    import l2_bus_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned ADDR_W         = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              l2REN,
    input  logic              l2WEN,
    input  logic [ADDR_W-1:0] l2addr,
    input  logic [31:0]       l2store,
    input  logic              abort_bus,
    output logic [31:0]       l2load,
    output l2_state_t         l2state,
    output logic              mem_ren,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_byte_en,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_busy
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ    = 3'd1,
        ACCESS = 3'd2,
        DRAIN  = 3'd3,
        ERR    = 3'd4
    } br_state_e;

    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

    br_state_e         state_q, state_d;
    logic              mem_ren_q, mem_ren_d;
    logic              mem_wen_q, mem_wen_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    word_t             mem_wdata_q, mem_wdata_d;
    word_t             l2load_q, l2load_d;

    logic tmr_en;
    logic tmr_clr;
    logic tmr_expired;
    logic req_drop;
    logic abandon;

    // Counter runs across REQ and DRAIN so an abandoned stall still times out.
    assign tmr_en  = (state_q == REQ) || (state_q == DRAIN);
    assign tmr_clr = !tmr_en || !mem_busy;

    l2_bridge_timer #(
        .CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .CLK      (CLK),
        .nRST     (nRST),
        .clear_i  (tmr_clr),
        .enable_i (tmr_en),
        .expired_o(tmr_expired)
    );

    assign req_drop = mem_wen_q ? !l2WEN : !l2REN;
    assign abandon  = abort_bus || req_drop;

    always_comb begin
        state_d     = state_q;
        mem_ren_d   = mem_ren_q;
        mem_wen_d   = mem_wen_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        l2load_d    = l2load_q;
        unique case (state_q)
            IDLE: begin
                if (l2WEN && !abort_bus) begin
                    state_d     = REQ;
                    mem_wen_d   = 1'b1;
                    mem_addr_d  = l2addr & WORD_MASK;
                    mem_wdata_d = l2store;
                end else if (l2REN && !abort_bus) begin
                    state_d    = REQ;
                    mem_ren_d  = 1'b1;
                    mem_addr_d = l2addr & WORD_MASK;
                end
            end
            REQ: begin
                if (!mem_busy) begin
                    mem_ren_d = 1'b0;
                    mem_wen_d = 1'b0;
                    // Memory finished in the same cycle as an abandon: nothing left to drain.
                    if (abandon) begin
                        state_d = IDLE;
                    end else begin
                        state_d = ACCESS;
                        if (mem_ren_q)
                            l2load_d = mem_rdata;
                    end
                end else if (tmr_expired) begin
                    state_d   = ERR;
                    mem_ren_d = 1'b0;
                    mem_wen_d = 1'b0;
                end else if (abandon) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!mem_busy || tmr_expired) begin
                    state_d   = mem_busy ? ERR : IDLE;
                    mem_ren_d = 1'b0;
                    mem_wen_d = 1'b0;
                end
            end
            ACCESS:  state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= IDLE;
            mem_ren_q   <= 1'b0;
            mem_wen_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            l2load_q    <= '0;
        end else begin
            state_q     <= state_d;
            mem_ren_q   <= mem_ren_d;
            mem_wen_q   <= mem_wen_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            l2load_q    <= l2load_d;
        end
    end

    always_comb begin
        l2state = L2_FREE;
        unique case (state_q)
            IDLE:    l2state = L2_FREE;
            REQ:     l2state = L2_BUSY;
            DRAIN:   l2state = L2_BUSY;
            ACCESS:  l2state = L2_ACCESS;
            ERR:     l2state = L2_ERROR;
            default: l2state = L2_FREE;
        endcase
    end

    assign mem_ren     = mem_ren_q;
    assign mem_wen     = mem_wen_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_byte_en = BYTE_EN_ALL;
    assign l2load      = l2load_q;

endmodule
